// File: rtl/bitreg_write_arbiter.sv
// bitreg_write_arbiter
// Round-robin arbiter for the single bit-write port of the display register.
// It grants one requester at a time and forwards that requester's bit index
// and value with a one-cycle dp_valid strobe. It then waits for dp_done, or
// for a timeout, acks the owner and rotates priority.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous reset, active low
//   req_i           per-requester request level, held until ack
//   req_index_i     packed bit indices; requester i uses [i*IDX_W +: IDX_W]
//   req_value_i     per-requester bit value
//   ack_o           one-hot, one-cycle completion pulse to the owner
//   grant_o         one-hot current owner; zero when idle
//   dp_valid_o      one-cycle write strobe to the datapath
//   dp_bit_index_o  latched bit index of the owner
//   dp_bit_value_o  latched bit value of the owner
//   dp_done_i       datapath completion pulse
//   busy_o          high whenever the FSM is not idle
//   timeout_err_o   sticky timeout flag
//   err_clr_i       synchronous clear of timeout_err_o; a same-cycle set wins
module bitreg_write_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*IDX_W-1:0] req_index_i,
    input  logic [N_REQ-1:0]       req_value_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   dp_valid_o,
    output logic [IDX_W-1:0]       dp_bit_index_o,
    output logic                   dp_bit_value_o,
    input  logic                   dp_done_i,
    output logic                   busy_o,
    output logic                   timeout_err_o,
    input  logic                   err_clr_i
);

    localparam int unsigned GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [GNT_W-1:0]    gidx_q, gidx_d;
    logic [GNT_W-1:0]    last_grant_q, last_grant_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                dp_valid_q, dp_valid_d;
    logic [IDX_W-1:0]    dp_bit_index_q, dp_bit_index_d;
    logic                dp_bit_value_q, dp_bit_value_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic                err_set;

    logic                pick_found;
    logic [GNT_W-1:0]    pick_idx;
    int unsigned         cand;

    // Round-robin pick: the first set request after last_grant, wrapping
    always_comb begin : pick_logic
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = 32'(last_grant_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_found && req_i[GNT_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = GNT_W'(cand);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin : fsm_comb
        state_d        = state_q;
        gidx_d         = gidx_q;
        last_grant_d   = last_grant_q;
        timer_d        = timer_q;
        grant_d        = grant_q;
        ack_d          = '0;
        dp_valid_d     = 1'b0;
        dp_bit_index_d = dp_bit_index_q;
        dp_bit_value_d = dp_bit_value_q;
        err_set        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = ISSUE;
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    dp_valid_d        = 1'b1;
                    dp_bit_index_d    = req_index_i[32'(pick_idx) * IDX_W +: IDX_W];
                    dp_bit_value_d    = req_value_i[pick_idx];
                    timer_d           = '0;
                end
            end
            ISSUE: begin
                // dp_done in this cycle is ignored
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                // dp_done has priority over a timeout in the same cycle
                if (dp_done_i) begin
                    state_d       = ACK;
                    ack_d[gidx_q] = 1'b1;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d       = ACK;
                    ack_d[gidx_q] = 1'b1;
                    err_set       = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ACK: begin
                state_d      = IDLE;
                last_grant_d = gidx_q;
                grant_d      = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Sticky error: a set in the same cycle as a clear wins
        if (err_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr_i) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin : fsm_regs
        if (!rst_ni) begin
            state_q        <= IDLE;
            gidx_q         <= '0;
            last_grant_q   <= GNT_W'(N_REQ - 1);
            timer_q        <= '0;
            grant_q        <= '0;
            ack_q          <= '0;
            dp_valid_q     <= 1'b0;
            dp_bit_index_q <= '0;
            dp_bit_value_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            gidx_q         <= gidx_d;
            last_grant_q   <= last_grant_d;
            timer_q        <= timer_d;
            grant_q        <= grant_d;
            ack_q          <= ack_d;
            dp_valid_q     <= dp_valid_d;
            dp_bit_index_q <= dp_bit_index_d;
            dp_bit_value_q <= dp_bit_value_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign ack_o          = ack_q;
    assign grant_o        = grant_q;
    assign dp_valid_o     = dp_valid_q;
    assign dp_bit_index_o = dp_bit_index_q;
    assign dp_bit_value_o = dp_bit_value_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: doc/bitreg_write_arbiter.md
Name: bitreg_write_arbiter

Overview:
- Round-robin arbiter that shares the single bit-write port of the 8-bit display register among N_REQ requesters (switch panel, debounced buttons, test sequencer, etc.).
- Grants one requester at a time and forwards its bit_index/bit_value with a one-cycle valid pulse.
- Waits for the datapath's completion pulse (or a timeout), acknowledges the requester, then rotates priority.
- Sits directly in front of the bit-write/valid handshake FSM feeding the 7-segment display.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 3, bit-index width (register width = 2**IDX_W).
- TIMEOUT, 15, max cycles spent in WAIT before forced completion (>=4).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req  input  N_REQ  per-requester request level; held until matching ack.
- req_index  input  N_REQ*IDX_W  packed bit indices; requester i uses slice [i*IDX_W +: IDX_W].
- req_value  input  N_REQ  per-requester bit value.
- ack  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- grant  output  N_REQ  one-hot current owner; all zero when idle.
- dp_valid  output  1  one-cycle write strobe to the datapath (its valid_in).
- dp_bit_index  output  IDX_W  latched index of the granted requester.
- dp_bit_value  output  1  latched value of the granted requester.
- dp_done  input  1  datapath completion pulse (its valid_out).
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky flag, set on timeout.
- err_clr  input  1  synchronous clear of timeout_err.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async): state=IDLE; grant=0, ack=0, dp_valid=0, dp_bit_index=0, dp_bit_value=0, busy=0, timeout_err=0, timer=0, last_grant=N_REQ-1 so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo N_REQ.
  - Latch that requester's index and value into dp_bit_index/dp_bit_value, set grant one-hot, and go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE: dp_valid=1 for exactly this one cycle; clear timer; go to WAIT. dp_done in this cycle is ignored.
- WAIT:
  - dp_done=1 -> go to ACK.
  - Otherwise timer+1. If timer==TIMEOUT-1 -> go to ACK and set timeout_err.
  - If dp_done arrives in the same cycle as the timeout, dp_done wins and timeout_err is not set.
- ACK:
  - ack[g]=1 for one cycle; last_grant<=g; then grant cleared and go to IDLE.
  - Every request takes at least one IDLE cycle between grants.
- dp_bit_index and dp_bit_value stay stable from ISSUE through ACK; their values after ACK are don't-care but hold.
- Latency: req sampled high in IDLE at edge k gives grant and dp_valid at k+1, WAIT from k+2. Minimum turnaround with dp_done at k+2 is ack at k+3.
- Requester rules:
  - Deasserting req after grant does not abort the transaction; it still completes and acks.
  - Changes to req_index/req_value after grant are ignored.
  - A requester still holding req after its ack is treated as a new request at lowest priority.
- timeout_err: sticky; cleared only by reset or err_clr=1. If err_clr and a timeout set occur in the same cycle, set wins.
- Reset mid-transaction: the transaction is abandoned with no ack, and priority returns to requester 0.
- Stray dp_done in IDLE or ACK: ignored, no state change.

Test Plan:
- Single request: req=4'b0010, index 3'd5, value 1; dp_done 3 cycles after dp_valid -> grant=0010, one dp_valid pulse carrying index 5 / value 1, ack=0010 one cycle after dp_done, busy low after.
- Round-robin: req=4'b1111 held, each dp_done returned promptly -> grant order 0,1,2,3,0; exactly one ack per grant.
- Timeout: req=4'b0001, dp_done never asserted, TIMEOUT=15 -> ack after 15 WAIT cycles, timeout_err=1; err_clr pulse -> timeout_err=0.
- Done/timeout collision: dp_done asserted on the final WAIT cycle -> ack issued, timeout_err stays 0.
- Async reset: reset=0 mid-WAIT -> all outputs 0 immediately, no ack; after release, req=4'b1001 -> requester 0 granted first.
- Input churn: after grant, change req_index 2->7 and drop req -> dp_bit_index stays 2, ack still issued, no second grant.
